regfile_sb: RTL

Next-generation decode-stage register file. Parametrised read/write port counts, with tag-compare forwarding computed internally from EX/MEM/WB stage tags (replaces externally generated bypass enables). Adds a per-register pending-write scoreboard that produces per-port ready bits and a decode stall. Sits in decode; consumed by the hazard unit and the ID/EX pipeline register.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_sb_fwd.sv | 64 ++++++
 rtl/regfile_sb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and forwarding-source encoding for regfile_sb
package regfile_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REG_NUM_DEF   = 32;
  localparam int ADDR_SIZE_DEF = 5;

  typedef enum logic [1:0] {
    FWD_EX  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_RF  = 2'd3
  } fwd_src_e;

endpackage

// File: rtl/regfile_sb_fwd.sv
// rtl/regfile_sb_fwd.sv - per-read-port tag compare and priority bypass mux
module regfile_sb_fwd
  import regfile_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int NUM_WR    = 2
) (
  input  logic [ADDR_SIZE-1:0]        addr_i,
  input  logic                        ex_valid_i,
  input  logic [ADDR_SIZE-1:0]        ex_rd_i,
  input  logic [XLEN-1:0]             ex_data_i,
  input  logic                        ex_data_ok_i,
  input  logic                        mem_valid_i,
  input  logic [ADDR_SIZE-1:0]        mem_rd_i,
  input  logic [XLEN-1:0]             mem_data_i,
  input  logic [NUM_WR-1:0]           wb_we_i,
  input  logic [NUM_WR*ADDR_SIZE-1:0] wb_rd_i,
  input  logic [NUM_WR*XLEN-1:0]      wb_data_i,
  input  logic [XLEN-1:0]             rf_data_i,
  input  logic                        rf_pending_i,
  output logic [XLEN-1:0]             data_o,
  output logic                        ready_o,
  output fwd_src_e                    src_o
);

  logic            wb_hit;
  logic [XLEN-1:0] wb_sel;

  // Later writeback ports override earlier ones, matching the array write order.
  always_comb begin
    wb_hit = 1'b0;
    wb_sel = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wb_we_i[j] && (wb_rd_i[j*ADDR_SIZE +: ADDR_SIZE] == addr_i)) begin
        wb_hit = 1'b1;
        wb_sel = wb_data_i[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    data_o  = rf_data_i;
    ready_o = ~rf_pending_i;
    src_o   = FWD_RF;
    if (addr_i == '0) begin
      data_o  = '0;
      ready_o = 1'b1;
    end else if (ex_valid_i && (ex_rd_i == addr_i)) begin
      data_o  = ex_data_i;
      ready_o = ex_data_ok_i;
      src_o   = FWD_EX;
    end else if (mem_valid_i && (mem_rd_i == addr_i)) begin
      data_o  = mem_data_i;
      ready_o = 1'b1;
      src_o   = FWD_MEM;
    end else if (wb_hit) begin
      data_o  = wb_sel;
      ready_o = 1'b1;
      src_o   = FWD_WB;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - decode register file with internal forwarding and pending-write scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_NUM   = REG_NUM_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  parameter int PEND_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_RD*ADDR_SIZE-1:0] rd_addr,
  input  logic [NUM_RD-1:0]           rd_used,
  output logic [NUM_RD*XLEN-1:0]      rd_data,
  output logic [NUM_RD-1:0]           rd_ready,
  output logic                        stall,
  input  logic                        iss_valid,
  input  logic [ADDR_SIZE-1:0]        iss_rd,
  input  logic                        ex_valid,
  input  logic [ADDR_SIZE-1:0]        ex_rd,
  input  logic [XLEN-1:0]             ex_data,
  input  logic                        ex_data_ok,
  input  logic                        mem_valid,
  input  logic [ADDR_SIZE-1:0]        mem_rd,
  input  logic [XLEN-1:0]             mem_data,
  input  logic [NUM_WR-1:0]           wb_we,
  input  logic [NUM_WR*ADDR_SIZE-1:0] wb_rd,
  input  logic [NUM_WR*XLEN-1:0]      wb_data,
  output logic                        sb_overflow
);

  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  logic [XLEN-1:0]   regs_q [REG_NUM];
  logic [XLEN-1:0]   regs_d [REG_NUM];
  logic [PEND_W-1:0] cnt_q  [REG_NUM];
  logic [PEND_W-1:0] cnt_d  [REG_NUM];
  logic              ovf_q, ovf_d;

  fwd_src_e          rd_src [NUM_RD];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_SIZE-1:0] addr;
    logic [XLEN-1:0]      rf_data;
    logic                 rf_pending;
    logic                 in_range;

    assign addr     = rd_addr[i*ADDR_SIZE +: ADDR_SIZE];
    assign in_range = (int'(addr) < REG_NUM);
    assign rf_data    = in_range ? regs_q[addr] : '0;
    assign rf_pending = in_range ? (cnt_q[addr] != '0) : 1'b0;

    regfile_sb_fwd #(
      .XLEN      (XLEN),
      .ADDR_SIZE (ADDR_SIZE),
      .NUM_WR    (NUM_WR)
    ) u_fwd (
      .addr_i       (addr),
      .ex_valid_i   (ex_valid),
      .ex_rd_i      (ex_rd),
      .ex_data_i    (ex_data),
      .ex_data_ok_i (ex_data_ok),
      .mem_valid_i  (mem_valid),
      .mem_rd_i     (mem_rd),
      .mem_data_i   (mem_data),
      .wb_we_i      (wb_we),
      .wb_rd_i      (wb_rd),
      .wb_data_i    (wb_data),
      .rf_data_i    (rf_data),
      .rf_pending_i (rf_pending),
      .data_o       (rd_data[i*XLEN +: XLEN]),
      .ready_o      (rd_ready[i]),
      .src_o        (rd_src[i])
    );

    // An EX-sourced operand is only ready when EX has its result (not a load).
    a_ex_ready : assert property (@(posedge clk) disable iff (!rst_n)
      (rd_src[i] != FWD_EX) || (rd_ready[i] == ex_data_ok));
  end

  assign stall       = |(rd_used & ~rd_ready);
  assign sb_overflow = ovf_q;

  always_comb begin
    logic inc;
    logic dec;
    inc    = 1'b0;
    dec    = 1'b0;
    regs_d = regs_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    for (int r = 1; r < REG_NUM; r++) begin
      inc = iss_valid && !stall && (iss_rd == ADDR_SIZE'(r));
      dec = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wb_we[j] && (wb_rd[j*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(r))) begin
          regs_d[r] = wb_data[j*XLEN +: XLEN];
          dec       = 1'b1;
        end
      end
      // Untracked writebacks against an idle counter are legal and leave it at zero.
      if (inc && !dec) begin
        if (cnt_q[r] == CNT_MAX) ovf_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_NUM; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule
